// File: rtl/decode_fetch_sequencer.sv
// Instruction-byte front end: circular byte queue, legacy-prefix/0x0F stripping,
// and a 9-byte opcode-aligned window handed to the opcode decoder.
module decode_fetch_sequencer #(
  parameter int DEPTH      = 16,
  parameter int MAX_PREFIX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [3:0]  consume_len,
  output logic [71:0] unescaped_instr,
  output logic        is_2byte,
  output logic        pfx_opsize,
  output logic        pfx_adsize,
  output logic        pfx_lock,
  output logic        pfx_rep,
  output logic        pfx_repne,
  output logic [2:0]  pfx_seg,
  output logic        err,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(MAX_PREFIX + 2);

  typedef enum logic [1:0] {
    PARSE = 2'd0,
    FILL  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          last_seen;
  logic [PW-1:0] pfx_cnt;

  logic          push;
  logic [3:0]    pop_n;
  logic          pfx_take, esc_take, clr_instr, set_err;
  logic          len_ok;
  logic [7:0]    head_byte;
  logic          is_pfx;
  logic [4:0]    pfx_set;   // {opsize, adsize, lock, rep, repne}
  logic [2:0]    seg_set;

  // Both ports transfer on a cycle where valid && ready are high at the rising
  // edge; valid never depends on ready, and the window holds until accepted.
  assign in_ready  = (count < CW'(DEPTH)) && !last_seen && !err;
  assign push      = in_valid && in_ready;
  assign head_byte = mem[head];
  assign state_dbg = state;
  assign len_ok    = (consume_len != 4'd0) && (consume_len <= 4'd9) &&
                     (CW'(consume_len) <= count);
  // A dangling prefix run at end of stream faults instead of reporting done.
  assign done      = last_seen && (count == '0) && (state == PARSE) && (pfx_cnt == '0);

  always_comb begin
    is_pfx  = 1'b1;
    pfx_set = '0;
    seg_set = '0;
    case (head_byte)
      8'h66:   pfx_set = 5'b10000;
      8'h67:   pfx_set = 5'b01000;
      8'hF0:   pfx_set = 5'b00100;
      8'hF3:   pfx_set = 5'b00010;
      8'hF2:   pfx_set = 5'b00001;
      8'h26:   seg_set = 3'd1;
      8'h2E:   seg_set = 3'd2;
      8'h36:   seg_set = 3'd3;
      8'h3E:   seg_set = 3'd4;
      8'h64:   seg_set = 3'd5;
      8'h65:   seg_set = 3'd6;
      default: is_pfx  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PARSE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop_n      = 4'd0;
    pfx_take   = 1'b0;
    esc_take   = 1'b0;
    clr_instr  = 1'b0;
    set_err    = 1'b0;
    out_valid  = 1'b0;
    case (state)
      PARSE: begin
        if (count == '0) begin
          if (last_seen && pfx_cnt != '0) begin
            set_err    = 1'b1;
            state_next = HALT;
          end
        end else if (is_pfx) begin
          if (pfx_cnt == PW'(MAX_PREFIX)) begin
            set_err    = 1'b1;
            state_next = HALT;
          end else begin
            pfx_take = 1'b1;
            pop_n    = 4'd1;
          end
        end else if (head_byte == 8'h0F) begin
          esc_take   = 1'b1;
          pop_n      = 4'd1;
          state_next = FILL;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        out_valid = (count >= CW'(9)) || last_seen;
        if (out_valid && out_ready) begin
          if (len_ok) begin
            pop_n      = consume_len;
            clr_instr  = 1'b1;
            state_next = PARSE;
          end else begin
            set_err    = 1'b1;
            state_next = HALT;
          end
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_seen  <= 1'b0;
      err        <= 1'b0;
      pfx_cnt    <= '0;
      is_2byte   <= 1'b0;
      pfx_opsize <= 1'b0;
      pfx_adsize <= 1'b0;
      pfx_lock   <= 1'b0;
      pfx_rep    <= 1'b0;
      pfx_repne  <= 1'b0;
      pfx_seg    <= 3'd0;
    end else begin
      if (push) tail <= tail + AW'(1);
      head  <= head + AW'(pop_n);
      count <= count + CW'(push) - CW'(pop_n);
      if (push && in_last) last_seen <= 1'b1;
      if (set_err) err <= 1'b1;
      if (clr_instr) begin
        pfx_cnt    <= '0;
        is_2byte   <= 1'b0;
        pfx_opsize <= 1'b0;
        pfx_adsize <= 1'b0;
        pfx_lock   <= 1'b0;
        pfx_rep    <= 1'b0;
        pfx_repne  <= 1'b0;
        pfx_seg    <= 3'd0;
      end else begin
        if (pfx_take) begin
          pfx_cnt    <= pfx_cnt + PW'(1);
          pfx_opsize <= pfx_opsize | pfx_set[4];
          pfx_adsize <= pfx_adsize | pfx_set[3];
          pfx_lock   <= pfx_lock   | pfx_set[2];
          pfx_rep    <= pfx_rep    | pfx_set[1];
          pfx_repne  <= pfx_repne  | pfx_set[0];
          if (seg_set != 3'd0) pfx_seg <= seg_set;
        end
        if (esc_take) is_2byte <= 1'b1;
      end
    end
  end

  // Window bytes past the occupied region read as zero.
  always_comb begin
    unescaped_instr = '0;
    for (int k = 0; k < 9; k++) begin
      if (CW'(k) < count) unescaped_instr[8*k +: 8] = mem[head + AW'(k)];
    end
  end

endmodule

// File: tb/tb_decode_fetch_sequencer.sv
// Self-checking bench for decode_fetch_sequencer: directed prefix/escape/end-of-stream
// cases, error cases, and a 40-instruction stream with random stalls.
module tb_decode_fetch_sequencer;

  localparam int RW = 81;  // {is_2byte, opsize, adsize, lock, rep, repne, seg[2:0], window[71:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  consume_len = '0;
  logic [71:0] unescaped_instr;
  logic        is_2byte, pfx_opsize, pfx_adsize, pfx_lock, pfx_rep, pfx_repne;
  logic [2:0]  pfx_seg;
  logic        err, done;
  logic [1:0]  state_dbg;

  decode_fetch_sequencer #(.DEPTH(16), .MAX_PREFIX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .consume_len(consume_len),
    .unescaped_instr(unescaped_instr), .is_2byte(is_2byte),
    .pfx_opsize(pfx_opsize), .pfx_adsize(pfx_adsize), .pfx_lock(pfx_lock),
    .pfx_rep(pfx_rep), .pfx_repne(pfx_repne), .pfx_seg(pfx_seg),
    .err(err), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] exp_q[$];
  logic [7:0]    stream[$];
  int            starts[$];
  int            lens[$];
  logic [8:0]    iflags[$];

  logic [7:0] ptab [11] = '{8'h66, 8'h67, 8'hF0, 8'hF3, 8'hF2,
                            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] observed();
    return {is_2byte, pfx_opsize, pfx_adsize, pfx_lock, pfx_rep, pfx_repne,
            pfx_seg, unescaped_instr};
  endfunction

  task automatic clear_model();
    stream.delete(); starts.delete(); lens.delete(); iflags.delete(); exp_q.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; consume_len = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // ---------------- stimulus model ----------------
  // Prefix bytes are listed low byte first; body byte 0 is the opcode.
  task automatic add_instr(input int npfx, input logic [31:0] pb, input bit esc,
                           input int len, input logic [71:0] body);
    logic [8:0] f;
    logic [7:0] b;
    f = '0;
    for (int i = 0; i < npfx; i++) begin
      b = pb[8*i +: 8];
      stream.push_back(b);
      case (b)
        8'h66: f[7] = 1'b1;
        8'h67: f[6] = 1'b1;
        8'hF0: f[5] = 1'b1;
        8'hF3: f[4] = 1'b1;
        8'hF2: f[3] = 1'b1;
        8'h26: f[2:0] = 3'd1;
        8'h2E: f[2:0] = 3'd2;
        8'h36: f[2:0] = 3'd3;
        8'h3E: f[2:0] = 3'd4;
        8'h64: f[2:0] = 3'd5;
        8'h65: f[2:0] = 3'd6;
        default: ;
      endcase
    end
    if (esc) begin
      stream.push_back(8'h0F);
      f[8] = 1'b1;
    end
    starts.push_back(stream.size());
    for (int k = 0; k < len; k++) stream.push_back(body[8*k +: 8]);
    lens.push_back(len);
    iflags.push_back(f);
  endtask

  task automatic add_filler(input int n);
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- drivers ----------------
  task automatic push_byte(input logic [7:0] b, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_byte = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("push_ready", in_ready, 1);
    else @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out_valid();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 500) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic accept(input int len);
    out_ready = 1'b1; consume_len = 4'(len);
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic consume_one(input int len, input bit stall_en);
    logic [RW-1:0] e;
    int stall;
    wait_out_valid();
    check("out_valid_wait", out_valid, 1);
    if (!out_valid) return;
    e = exp_q.pop_front();
    stall = stall_en ? $urandom_range(0, 3) : 0;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", observed(), e);
      @(negedge clk);
    end
    check("window", observed(), e);
    accept(len);
  endtask

  // Expected records are queued for every instruction before the stream is driven.
  task automatic run_stream(input bit use_last, input bit stall_en);
    logic [71:0] w;
    int j;
    foreach (starts[i]) begin
      w = '0;
      for (int k = 0; k < 9; k++) begin
        j = starts[i] + k;
        if (j < stream.size()) w[8*k +: 8] = stream[j];
      end
      exp_q.push_back({iflags[i], w});
    end
    fork
      begin : pusher
        for (int i = 0; i < stream.size(); i++) begin
          if (stall_en && $urandom_range(0, 3) == 0) @(negedge clk);
          push_byte(stream[i], use_last && (i == stream.size() - 1));
        end
      end
      begin : consumer
        for (int i = 0; i < lens.size(); i++) consume_one(lens[i], stall_en);
      end
    join
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [71:0] body;
    int npfx, len;
    logic [31:0] pb;

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_record", observed(), '0);
    check("rst_state", state_dbg, 0);
    reset_dut();

    // 1-byte opcode, then the next byte becomes the opcode
    add_instr(0, '0, 1'b0, 1, 72'h90);
    add_instr(0, '0, 1'b0, 1, 72'h01);
    for (int i = 2; i <= 9; i++) stream.push_back(8'(i));
    run_stream(1'b0, 1'b0);
    @(negedge clk);
    check("no_done", done, 0);
    reset_dut();

    // opsize + rep prefixes and 0x0F escape
    add_instr(2, 32'h0000_F366, 1'b1, 2, 72'hC3AF);
    add_filler(8);
    run_stream(1'b0, 1'b0);
    reset_dut();

    // segment override: last one wins, plus lock
    add_instr(4, 32'hF026_642E, 1'b0, 1, 72'h90);
    add_filler(9);
    run_stream(1'b0, 1'b0);
    reset_dut();

    // five prefixes exceed the limit
    push_byte(8'h66, 1'b0); push_byte(8'h67, 1'b0); push_byte(8'hF0, 1'b0);
    push_byte(8'hF3, 1'b0); push_byte(8'hF2, 1'b0);
    repeat (4) @(negedge clk);
    check("pfx_over_err", err, 1);
    check("pfx_over_in_ready", in_ready, 0);
    check("pfx_over_out_valid", out_valid, 0);
    check("pfx_over_state", state_dbg, 2);
    reset_dut();

    // short final stream with zero padding, then done
    add_instr(0, '0, 1'b0, 1, 72'hC3);
    add_instr(0, '0, 1'b0, 1, 72'h90);
    add_instr(0, '0, 1'b0, 1, 72'h90);
    run_stream(1'b1, 1'b0);
    @(negedge clk);
    check("done", done, 1);
    check("done_in_ready", in_ready, 0);
    reset_dut();

    // consume_len larger than what is queued
    push_byte(8'hC3, 1'b0); push_byte(8'h90, 1'b0); push_byte(8'h90, 1'b1);
    wait_out_valid();
    check("short_valid", out_valid, 1);
    check("short_window", unescaped_instr, 72'h9090C3);
    accept(4);
    @(negedge clk);
    check("badlen_err", err, 1);
    check("badlen_out_valid", out_valid, 0);
    check("badlen_no_pop", unescaped_instr, 72'h9090C3);
    check("badlen_done", done, 0);
    reset_dut();

    // zero consume_len is illegal too
    push_byte(8'h90, 1'b1);
    wait_out_valid();
    accept(0);
    @(negedge clk);
    check("zerolen_err", err, 1);
    reset_dut();

    // long random stream with stalls, wrapping the queue many times
    for (int n = 0; n < 40; n++) begin
      npfx = $urandom_range(0, 2);
      pb = '0;
      for (int i = 0; i < npfx; i++) pb[8*i +: 8] = ptab[$urandom_range(0, 10)];
      len = $urandom_range(1, 9);
      body = {$urandom(), $urandom(), $urandom()};
      body[7:0] = 8'(8'h80 + $urandom_range(0, 63));
      add_instr(npfx, pb, 1'($urandom_range(0, 1)), len, body);
    end
    run_stream(1'b1, 1'b1);
    @(negedge clk);
    check("stream_done", done, 1);
    check("stream_err", err, 0);
    check("stream_exp_empty", exp_q.size(), 0);
    reset_dut();

    // asynchronous reset while a window is presented
    add_filler(10);
    stream[0] = 8'h90;
    for (int i = 0; i < 10; i++) push_byte(stream[i], 1'b0);
    wait_out_valid();
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_record", observed(), '0);
    check("arst_state", state_dbg, 0);
    check("arst_err_done", {err, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
